// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: state encoding and default widths common to the
// read and write drivers.
package pipeline_pkg;

    localparam int unsigned DEFAULT_ADDR_SIZE  = 5;
    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    // Codes are visible on the debug hex display, so they are fixed explicitly.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Zero-extend a state code to one hex digit for the debug display.
    function automatic logic [3:0] state_hex(input state_e s);
        return {2'b00, s};
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// LATENCY-deep 1-bit shift register that tracks which datapath slots carry a
// valid operand pair. Synchronous flush, asynchronous active-low reset.
module valid_delay_line #(
    parameter int unsigned LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [LATENCY-1:0] stage_q;
    logic [LATENCY-1:0] stage_d;

    // Shift toward the tap; the shift form also covers LATENCY = 1.
    always_comb begin
        stage_d = (stage_q << 1) | LATENCY'(din);
        if (flush) begin
            stage_d = '0;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[LATENCY-1];

endmodule

// File: rtl/write_driver.sv
// Write driver: delays the read-issue strobe by the datapath latency and commits
// each result word to the result RAM at consecutive addresses, pulsing o_done
// after NUM_RESULTS writes.
// Optional feature: define WRITE_DRIVER_OVERRUN_EN to add the sticky o_overrun flag.
module write_driver
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_SIZE   = DEFAULT_ADDR_SIZE,
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned NUM_RESULTS = 16,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic                  i_rden,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_wren,
    output logic [ADDR_SIZE-1:0]  o_wraddr,
    output logic [DATA_WIDTH-1:0] o_wrdata,
    output logic                  o_done,
`ifdef WRITE_DRIVER_OVERRUN_EN
    output logic                  o_overrun,
`endif
    output logic [3:0]            o_state_HEX0
);

    localparam logic [ADDR_SIZE-1:0] LastCount = ADDR_SIZE'(NUM_RESULTS - 1);
    localparam logic [ADDR_SIZE-1:0] BaseAddr  = ADDR_SIZE'(BASE_ADDR);

    state_e                  state_q, state_d;
    logic [ADDR_SIZE-1:0]    count_q, count_d;
    logic                    wren_q, wren_d;
    logic [ADDR_SIZE-1:0]    wraddr_q, wraddr_d;
    logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
    logic                    done_q, done_d;
    logic                    valid;
`ifdef WRITE_DRIVER_OVERRUN_EN
    logic                    overrun_q, overrun_d;
`endif

    valid_delay_line #(
        .LATENCY (LATENCY)
    ) u_valid_delay_line (
        .clk   (i_CLK),
        .rst_n (i_RST_N),
        .flush (i_clear),
        .din   (i_rden),
        .dout  (valid)
    );

    // Next-state and commit decode; clear overrides everything.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wren_d   = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        done_d   = 1'b0;
`ifdef WRITE_DRIVER_OVERRUN_EN
        overrun_d = overrun_q;
`endif
        if (i_clear) begin
            state_d = StIdle;
            count_d = '0;
`ifdef WRITE_DRIVER_OVERRUN_EN
            overrun_d = 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle, StWrite: begin
                    if (valid) begin
                        wren_d   = 1'b1;
                        wrdata_d = i_data;
                        wraddr_d = BaseAddr + count_q;
                        count_d  = count_q + ADDR_SIZE'(1);
                        state_d  = (count_q == LastCount) ? StDone : StWrite;
                    end
                end
                StDone: begin
                    // A result arriving here is an overrun and is never written.
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = StIdle;
`ifdef WRITE_DRIVER_OVERRUN_EN
                    if (valid) begin
                        overrun_d = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q  <= StIdle;
            count_q  <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= BaseAddr;
            wrdata_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            done_q   <= done_d;
        end
    end

`ifdef WRITE_DRIVER_OVERRUN_EN
    // Sticky overrun flag.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign o_overrun = overrun_q;
`endif

    assign o_wren       = wren_q;
    assign o_wraddr     = wraddr_q;
    assign o_wrdata     = wrdata_q;
    assign o_done       = done_q;
    assign o_state_HEX0 = state_hex(state_q);

endmodule

// File: tb/tb_write_driver.sv
// Table-driven bench for write_driver: dut_a uses the default parameters,
// dut_b is configured for address wrap (BASE_ADDR=30, NUM_RESULTS=4).
module tb_write_driver;

    typedef struct {
        logic        sel;    // 0: dut_a, 1: dut_b
        logic        rst;
        logic        rden;
        logic        clr;
        logic [15:0] data;
        logic        wren;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic        done;
        logic [3:0]  st;
        logic        ovr;
    } vec_t;

    vec_t vecs[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rden = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] data = '0;

    logic        a_wren, b_wren, a_done, b_done;
    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [3:0]  a_st, b_st;
    logic        a_ovr, b_ovr;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    write_driver #(
        .ADDR_SIZE   (5),
        .DATA_WIDTH  (16),
        .LATENCY     (2),
        .NUM_RESULTS (16),
        .BASE_ADDR   (0)
    ) dut_a (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_rden       (rden),
        .i_clear      (clr),
        .i_data       (data),
        .o_wren       (a_wren),
        .o_wraddr     (a_addr),
        .o_wrdata     (a_wdata),
        .o_done       (a_done),
`ifdef WRITE_DRIVER_OVERRUN_EN
        .o_overrun    (a_ovr),
`endif
        .o_state_HEX0 (a_st)
    );

    write_driver #(
        .ADDR_SIZE   (5),
        .DATA_WIDTH  (16),
        .LATENCY     (2),
        .NUM_RESULTS (4),
        .BASE_ADDR   (30)
    ) dut_b (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_rden       (rden),
        .i_clear      (clr),
        .i_data       (data),
        .o_wren       (b_wren),
        .o_wraddr     (b_addr),
        .o_wrdata     (b_wdata),
        .o_done       (b_done),
`ifdef WRITE_DRIVER_OVERRUN_EN
        .o_overrun    (b_ovr),
`endif
        .o_state_HEX0 (b_st)
    );

`ifndef WRITE_DRIVER_OVERRUN_EN
    assign a_ovr = 1'b0;
    assign b_ovr = 1'b0;
`endif

    task automatic check(input string tname, input string what, input int cyc,
                         input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s.%s cycle %0d: got %h, expected %h", tname, what, cyc, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic add(input logic sel, input logic rst, input logic rd, input logic cl,
                       input logic [15:0] d, input logic we, input logic [4:0] ad,
                       input logic [15:0] wd, input logic dn, input logic [3:0] st,
                       input logic ov);
        vec_t v;
        v.sel = sel; v.rst = rst; v.rden = rd; v.clr = cl; v.data = d;
        v.wren = we; v.addr = ad; v.wdata = wd; v.done = dn; v.st = st; v.ovr = ov;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rden = 1'b0;
        clr = 1'b0;
        data = '0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // Cycle c: inputs driven just after edge c, outputs sampled at the falling edge.
    task automatic run_vectors(input string tname);
        logic        we, dn, ov;
        logic [4:0]  ad;
        logic [15:0] wd;
        logic [3:0]  st;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n = ~vecs[i].rst;
            rden  = vecs[i].rden;
            clr   = vecs[i].clr;
            data  = vecs[i].data;
            @(negedge clk);
            if (vecs[i].sel) begin
                we = b_wren; ad = b_addr; wd = b_wdata; dn = b_done; st = b_st; ov = b_ovr;
            end else begin
                we = a_wren; ad = a_addr; wd = a_wdata; dn = a_done; st = a_st; ov = a_ovr;
            end
            check(tname, "wren", i, 16'(we), 16'(vecs[i].wren));
            check(tname, "wraddr", i, 16'(ad), 16'(vecs[i].addr));
            check(tname, "wrdata", i, wd, vecs[i].wdata);
            check(tname, "done", i, 16'(dn), 16'(vecs[i].done));
            check(tname, "state", i, 16'(st), 16'(vecs[i].st));
`ifdef WRITE_DRIVER_OVERRUN_EN
            check(tname, "overrun", i, 16'(ov), 16'(vecs[i].ovr));
`endif
        end
        vecs.delete();
    endtask

    initial begin
        int          p[6];
        int          n;
        logic [4:0]  ea;
        logic [15:0] ed;
        logic [3:0]  es;

        // Reset held with rden toggling, then released: nothing may leak out.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            add(1'b0, c < 6, (c < 6) ? c[0] : 1'b0, 1'b0, 16'h5A00 + 16'(c),
                1'b0, 5'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        end
        run_vectors("reset");

        // Back-to-back burst of 16.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            if (c < 3) es = 4'd0;
            else if (c < 18) es = 4'd1;
            else if (c == 18) es = 4'd2;
            else es = 4'd0;
            add(1'b0, 1'b0, c <= 15, 1'b0,
                (c >= 2) ? 16'hA000 + 16'(c - 2) : 16'hDEAD,
                c >= 3 && c <= 18,
                (c < 3) ? 5'd0 : (c <= 18) ? 5'(c - 3) : 5'd15,
                (c < 3) ? 16'h0 : (c <= 18) ? 16'hA000 + 16'(c - 3) : 16'hA00F,
                c == 19, es, 1'b0);
        end
        run_vectors("burst");

        // Gapped issue 1,0,1,1,0,1.
        do_reset();
        p = '{1, 0, 1, 1, 0, 1};
        n = 0;
        ea = 5'd0;
        ed = 16'h0;
        for (int c = 0; c < 12; c++) begin
            logic we;
            we = (c >= 3 && c < 9) ? (p[c - 3] == 1) : 1'b0;
            if (we) begin
                ea = 5'(n);
                ed = 16'hB000 + 16'(c - 1);
                n++;
            end
            add(1'b0, 1'b0, (c < 6) ? (p[c] == 1) : 1'b0, 1'b0, 16'hB000 + 16'(c),
                we, ea, ed, 1'b0, (c < 3) ? 4'd0 : 4'd1, 1'b0);
        end
        run_vectors("gapped");

        // Address wrap on dut_b: 30, 31, 0, 1.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 3) es = 4'd0;
            else if (c < 6) es = 4'd1;
            else if (c == 6) es = 4'd2;
            else es = 4'd0;
            add(1'b1, 1'b0, c < 4, 1'b0, 16'hC000 + 16'(c),
                c >= 3 && c <= 6,
                (c < 3) ? 5'd30 : (c <= 6) ? 5'(27 + c) : 5'd1,
                (c < 3) ? 16'h0 : (c <= 6) ? 16'hC000 + 16'(c - 1) : 16'hC005,
                c == 7, es, 1'b0);
        end
        run_vectors("wrap");

        // Clear after 5 writes with 2 in flight, then a fresh pass from BASE_ADDR.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            logic we;
            we = (c >= 3 && c <= 7) || c == 13;
            if (c < 3) begin ea = 5'd0; ed = 16'h0; end
            else if (c <= 7) begin ea = 5'(c - 3); ed = 16'hD000 + 16'(c - 1); end
            else if (c < 13) begin ea = 5'd4; ed = 16'hD006; end
            else begin ea = 5'd0; ed = 16'hD00C; end
            if (c < 3) es = 4'd0;
            else if (c <= 7) es = 4'd1;
            else if (c < 13) es = 4'd0;
            else es = 4'd1;
            add(1'b0, 1'b0, c <= 6 || c == 10, c == 7, 16'hD000 + 16'(c),
                we, ea, ed, 1'b0, es, 1'b0);
        end
        run_vectors("clear");

        // 17 back-to-back issues: 17th lands in DONE and is dropped.
        do_reset();
        for (int c = 0; c < 25; c++) begin
            if (c < 3) es = 4'd0;
            else if (c < 18) es = 4'd1;
            else if (c == 18) es = 4'd2;
            else es = 4'd0;
            add(1'b0, 1'b0, c <= 16, c == 22, 16'hE000 + 16'(c),
                c >= 3 && c <= 18,
                (c < 3) ? 5'd0 : (c <= 18) ? 5'(c - 3) : 5'd15,
                (c < 3) ? 16'h0 : (c <= 18) ? 16'hE000 + 16'(c - 1) : 16'hE011,
                c == 19, es, c >= 19 && c <= 22);
        end
        run_vectors("overrun");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
